// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall controller: stall bus layout,
// stall codes and the mult/div sequencer state encoding.
package pipe_stall_ctrl_pkg;

  localparam int unsigned StallW = 6;

  localparam int unsigned StPc  = 0;
  localparam int unsigned StIf  = 1;
  localparam int unsigned StId  = 2;
  localparam int unsigned StEx  = 3;
  localparam int unsigned StMem = 4;
  localparam int unsigned StWb  = 5;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  typedef logic [StallW-1:0] stall_t;

  localparam stall_t StallMem  = 6'b011111;
  localparam stall_t StallEx   = 6'b001111;
  localparam stall_t StallLu   = 6'b000111;
  localparam stall_t StallNone = 6'b000000;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } md_state_e;

  // Total EX occupancy for the instruction being started.
  function automatic logic [5:0] md_len(input logic is_div, input logic [5:0] div_len,
                                        input logic [5:0] mul_len);
    return is_div ? div_len : mul_len;
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_md_seq_counter.sv
// HI/LO multiply/divide sequencer: IDLE/BUSY/DONE FSM with a 6-bit down counter.
// Produces the EX hold request, the result-capture strobe and the busy flag.
module pipe_stall_ctrl_md_seq_counter
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = 33,
  parameter int unsigned MUL_CYCLES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic md_start,
  input  logic md_is_div,
  input  logic mem_dwait,
  output logic ex_hold,
  output logic md_done,
  output logic md_busy
);

  localparam logic [5:0] DivLen = 6'(DIV_CYCLES);
  localparam logic [5:0] MulLen = 6'(MUL_CYCLES);

  md_state_e  state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [5:0] start_len;

  assign start_len = md_len(md_is_div, DivLen, MulLen);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      cnt_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (md_start) begin
          if (start_len == 6'd1) begin
            state_d = StDone;
          end else begin
            state_d = StBusy;
            cnt_d   = start_len - 6'd2;
          end
        end
      end
      StBusy: begin
        // Counts through mem_dwait; the transition at zero keeps cnt from wrapping.
        if (cnt_q == 6'd0) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      StDone: begin
        // Result stays presented until MEM lets EX actually advance.
        if (!mem_dwait) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ex_hold = 1'b0;
    md_done = 1'b0;
    md_busy = 1'b0;
    unique case (state_q)
      StIdle: ex_hold = md_start && (start_len != 6'd1);
      StBusy: begin
        ex_hold = 1'b1;
        md_busy = 1'b1;
      end
      StDone: begin
        md_done = 1'b1;
        md_busy = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central pipeline scheduler: merges MEM wait, mult/div EX hold and load-use
// requests into one stall bus, deepest request first.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int unsigned STALL_W    = 6,
  parameter int unsigned DIV_CYCLES = 33,
  parameter int unsigned MUL_CYCLES = 2
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               id_loaduse,
  input  logic               ex_md_start,
  input  logic               ex_md_is_div,
  input  logic               mem_dwait,
  output logic [STALL_W-1:0] stall,
  output logic               md_done,
  output logic               md_busy
);

  logic   ex_hold;
  logic   lu_req;
  logic   lu_win;
  logic   lu_done_q, lu_done_d;
  stall_t stall_code;

  pipe_stall_ctrl_md_seq_counter #(
    .DIV_CYCLES(DIV_CYCLES),
    .MUL_CYCLES(MUL_CYCLES)
  ) u_md_seq_counter (
    .clk      (clk),
    .resetn   (resetn),
    .md_start (ex_md_start),
    .md_is_div(ex_md_is_div),
    .mem_dwait(mem_dwait),
    .ex_hold  (ex_hold),
    .md_done  (md_done),
    .md_busy  (md_busy)
  );

  // One bubble per ID instruction; forwarding from MEM covers the rest.
  assign lu_req = id_loaduse && !lu_done_q;

  always_comb begin
    stall_code = StallNone;
    lu_win     = 1'b0;
    // Bus is forced quiet while reset is asserted, independent of the clock.
    if (!resetn) begin
      stall_code = StallNone;
    end else if (mem_dwait) begin
      stall_code = StallMem;
    end else if (ex_hold) begin
      stall_code = StallEx;
    end else if (lu_req) begin
      stall_code = StallLu;
      lu_win     = 1'b1;
    end
  end

  always_comb begin
    lu_done_d = lu_done_q;
    if (lu_win) begin
      lu_done_d = 1'b1;
    end else if (stall_code[StId] == NoStop) begin
      lu_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lu_done_q <= 1'b0;
    end else begin
      lu_done_q <= lu_done_d;
    end
  end

  assign stall = STALL_W'(stall_code);

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl; a second instance built with
// MUL_CYCLES = 1 shares the stimulus to cover the immediate-done case.
module tb_pipe_stall_ctrl;

  localparam logic [5:0] SMem  = 6'b011111;
  localparam logic [5:0] SEx   = 6'b001111;
  localparam logic [5:0] SLu   = 6'b000111;
  localparam logic [5:0] SNone = 6'b000000;

  logic       clk = 1'b0;
  logic       resetn;
  logic       id_loaduse, ex_md_start, ex_md_is_div, mem_dwait;
  logic [5:0] stall, stall1;
  logic       md_done, md_busy, md_done1, md_busy1;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  exp_e;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(
    .STALL_W(6), .DIV_CYCLES(33), .MUL_CYCLES(2)
  ) dut (
    .clk(clk), .resetn(resetn), .id_loaduse(id_loaduse), .ex_md_start(ex_md_start),
    .ex_md_is_div(ex_md_is_div), .mem_dwait(mem_dwait), .stall(stall),
    .md_done(md_done), .md_busy(md_busy)
  );

  pipe_stall_ctrl #(
    .STALL_W(6), .DIV_CYCLES(33), .MUL_CYCLES(1)
  ) dut_mul1 (
    .clk(clk), .resetn(resetn), .id_loaduse(id_loaduse), .ex_md_start(ex_md_start),
    .ex_md_is_div(ex_md_is_div), .mem_dwait(mem_dwait), .stall(stall1),
    .md_done(md_done1), .md_busy(md_busy1)
  );

  task automatic test_reset();
    resetn = 1'b0; id_loaduse = 1'b1; ex_md_start = 1'b1; ex_md_is_div = 1'b1;
    mem_dwait = 1'b1;
    #2;
    exp_q.push_back({SNone, 1'b0, 1'b0});
    exp_q.push_back({SNone, 1'b0, 1'b0});
    exp_e = exp_q.pop_front();
    n_vec++;
    if ({stall, md_done, md_busy} !== exp_e) begin
      n_err++;
      $display("FAIL reset: got %b want %b", {stall, md_done, md_busy}, exp_e);
    end
    exp_e = exp_q.pop_front();
    n_vec++;
    if ({stall1, md_done1, md_busy1} !== exp_e) begin
      n_err++;
      $display("FAIL reset_mul1: got %b want %b", {stall1, md_done1, md_busy1}, exp_e);
    end
    id_loaduse = 1'b0; ex_md_start = 1'b0; ex_md_is_div = 1'b0; mem_dwait = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_loaduse();
    logic [3:0] lu_pat = 4'b0111;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      id_loaduse = lu_pat[c];
      // Cycle 0 bubbles, cycle 1 ID advances, cycle 2 is a new instruction.
      exp_q.push_back({(c == 0 || c == 2) ? SLu : SNone, 1'b0, 1'b0});
      @(negedge clk);
      exp_e = exp_q.pop_front();
      n_vec++;
      if ({stall, md_done, md_busy} !== exp_e) begin
        n_err++;
        $display("FAIL loaduse c%0d: got %b want %b", c, {stall, md_done, md_busy}, exp_e);
      end
    end
    id_loaduse = 1'b0;
  endtask

  // Divide with start held: 33 EX-hold cycles (start + 32 BUSY), then DONE.
  task automatic test_div(input logic lu, input logic dwait_mid);
    logic [5:0] s;
    for (int c = 0; c <= 35; c++) begin
      @(posedge clk); #1;
      ex_md_start  = (c <= 33);
      ex_md_is_div = 1'b1;
      id_loaduse   = lu && (c <= 34);
      mem_dwait    = dwait_mid && (c >= 5) && (c <= 9);
      if (c <= 32)      s = (dwait_mid && c >= 5 && c <= 9) ? SMem : SEx;
      else if (c == 33) s = lu ? SLu : SNone;
      else              s = SNone;
      exp_q.push_back({s, c == 33, (c >= 1) && (c <= 33)});
      @(negedge clk);
      exp_e = exp_q.pop_front();
      n_vec++;
      if ({stall, md_done, md_busy} !== exp_e) begin
        n_err++;
        $display("FAIL div(lu=%0b,dw=%0b) c%0d: got %b want %b", lu, dwait_mid, c,
                 {stall, md_done, md_busy}, exp_e);
      end
    end
    ex_md_start = 1'b0; id_loaduse = 1'b0; mem_dwait = 1'b0;
  endtask

  task automatic test_reset_mid_div();
    for (int c = 0; c <= 22; c++) begin
      @(posedge clk); #1;
      ex_md_start = 1'b1; ex_md_is_div = 1'b1;
      exp_q.push_back({SEx, 1'b0, c >= 1});
      @(negedge clk);
      exp_e = exp_q.pop_front();
      n_vec++;
      if ({stall, md_done, md_busy} !== exp_e) begin
        n_err++;
        $display("FAIL rstdiv c%0d: got %b want %b", c, {stall, md_done, md_busy}, exp_e);
      end
    end
    // cnt is 10 here; reset lands mid-cycle with start still high.
    resetn = 1'b0;
    #1;
    exp_q.push_back({SNone, 1'b0, 1'b0});
    exp_e = exp_q.pop_front();
    n_vec++;
    if ({stall, md_done, md_busy} !== exp_e) begin
      n_err++;
      $display("FAIL rstdiv_async: got %b want %b", {stall, md_done, md_busy}, exp_e);
    end
    ex_md_start = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  // Two multiplies back to back: start held through DONE re-triggers in IDLE.
  task automatic test_back_to_back();
    logic [5:0] s;
    for (int c = 0; c <= 6; c++) begin
      @(posedge clk); #1;
      ex_md_start = (c <= 5); ex_md_is_div = 1'b0;
      s = (c == 0 || c == 1 || c == 3 || c == 4) ? SEx : SNone;
      exp_q.push_back({s, c == 2 || c == 5, c == 1 || c == 2 || c == 4 || c == 5});
      @(negedge clk);
      exp_e = exp_q.pop_front();
      n_vec++;
      if ({stall, md_done, md_busy} !== exp_e) begin
        n_err++;
        $display("FAIL b2b c%0d: got %b want %b", c, {stall, md_done, md_busy}, exp_e);
      end
    end
    ex_md_start = 1'b0;
  endtask

  task automatic test_mul1();
    for (int c = 0; c <= 3; c++) begin
      @(posedge clk); #1;
      ex_md_start = (c <= 1); ex_md_is_div = 1'b0;
      exp_q.push_back({SNone, c == 1, c == 1});
      @(negedge clk);
      exp_e = exp_q.pop_front();
      n_vec++;
      if ({stall1, md_done1, md_busy1} !== exp_e) begin
        n_err++;
        $display("FAIL mul1 c%0d: got %b want %b", c, {stall1, md_done1, md_busy1}, exp_e);
      end
    end
    ex_md_start = 1'b0;
  endtask

  task automatic test_dwait_done();
    logic [5:0] s;
    int         captures = 0;
    for (int c = 0; c <= 6; c++) begin
      @(posedge clk); #1;
      ex_md_start = (c <= 5); ex_md_is_div = 1'b0;
      mem_dwait   = (c >= 2) && (c <= 4);
      s = (c <= 1) ? SEx : (c <= 4) ? SMem : SNone;
      exp_q.push_back({s, (c >= 2) && (c <= 5), (c >= 1) && (c <= 5)});
      @(negedge clk);
      if (md_done && !mem_dwait) captures++;
      exp_e = exp_q.pop_front();
      n_vec++;
      if ({stall, md_done, md_busy} !== exp_e) begin
        n_err++;
        $display("FAIL dwait_done c%0d: got %b want %b", c, {stall, md_done, md_busy}, exp_e);
      end
    end
    n_vec++;
    if (captures !== 1) begin
      n_err++;
      $display("FAIL dwait_captures: got %0d want 1", captures);
    end
    ex_md_start = 1'b0; mem_dwait = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_loaduse();
    test_div(1'b0, 1'b0);
    test_reset_mid_div();
    test_div(1'b0, 1'b0);
    test_back_to_back();
    test_mul1();
    test_dwait_done();
    test_div(1'b0, 1'b1);
    test_div(1'b1, 1'b0);
    test_loaduse();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
